booth_mult: RTL and testbench

BOOTH_MULT -- requirements
Module: booth_mult

---
 rtl/booth_mult_pkg.sv | 7 +
 rtl/booth_mult_step.sv | 27 ++
 rtl/booth_mult.sv | 68 ++++++
 tb/tb_booth_mult.sv | 121 ++++++++++++
 4 files changed

// File: rtl/booth_mult_pkg.sv
// booth_mult_pkg: shared width, FSM state type and Booth pair encodings
package booth_mult_pkg;
  localparam int WIDTH = 32;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [1:0] PAIR_ADD = 2'b01;
  localparam logic [1:0] PAIR_SUB = 2'b10;
endpackage

// File: rtl/booth_mult_step.sv
// booth_step: one combinational radix-2 Booth iteration (add/sub then arithmetic shift)
module booth_step #(
  parameter int W = booth_mult_pkg::WIDTH
) (
  input  logic [W-1:0] acc_hi,
  input  logic [W-1:0] acc_lo,
  input  logic         q,
  input  logic [W-1:0] mcand,
  output logic [W-1:0] nxt_hi,
  output logic [W-1:0] nxt_lo,
  output logic         nxt_q
);
  import booth_mult_pkg::*;
  logic [W:0] hi_x;
  logic [W:0] m_x;
  logic [W:0] sum;
  // one extra bit keeps the most negative multiplicand exact through the shift
  always_comb begin
    hi_x   = {acc_hi[W-1], acc_hi};
    m_x    = {mcand[W-1], mcand};
    sum    = ({acc_lo[0], q} == PAIR_ADD) ? hi_x + m_x :
             ({acc_lo[0], q} == PAIR_SUB) ? hi_x - m_x : hi_x;
    nxt_hi = sum[W:1];
    nxt_lo = {sum[0], acc_lo[W-1:1]};
    nxt_q  = acc_lo[0];
  end
endmodule

// File: rtl/booth_mult.sv
// booth_mult: sequential radix-2 Booth signed multiplier, one iteration per clock
module booth_mult #(
  parameter int WIDTH = booth_mult_pkg::WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             MULT_START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             MULT_END,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  import booth_mult_pkg::*;
  state_t state, state_d;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, mcand, nxt_hi, nxt_lo;
  logic q, nxt_q, last;
  booth_step #(.W(WIDTH)) u_step (
    .acc_hi(acc_hi),
    .acc_lo(acc_lo),
    .q(q),
    .mcand(mcand),
    .nxt_hi(nxt_hi),
    .nxt_lo(nxt_lo),
    .nxt_q(nxt_q)
  );
  always_comb begin
    last    = (state == BUSY) && (cnt == CNT_W'(1)) && !MULT_START;
    state_d = MULT_START ? BUSY : last ? DONE : state;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      mcand    <= '0;
      q        <= 1'b0;
      HI       <= '0;
      LO       <= '0;
      MULT_END <= 1'b0;
    end else begin
      state <= state_d;
      if (MULT_START) begin
        mcand    <= A;
        acc_lo   <= B;
        acc_hi   <= '0;
        q        <= 1'b0;
        HI       <= '0;
        LO       <= '0;
        MULT_END <= 1'b0;
        cnt      <= CNT_W'(WIDTH);
      end else if (state == BUSY) begin
        acc_hi <= nxt_hi;
        acc_lo <= nxt_lo;
        q      <= nxt_q;
        cnt    <= cnt - CNT_W'(1);
        if (last) begin
          HI       <= nxt_hi;
          LO       <= nxt_lo;
          MULT_END <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_booth_mult.sv
// tb_booth_mult: directed-vector self-checking bench for booth_mult
module tb_booth_mult;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic MULT_START = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic MULT_END;
  logic [31:0] HI, LO;
  int total = 0;
  int bad = 0;

  booth_mult dut (
    .clock(clock),
    .reset(reset),
    .MULT_START(MULT_START),
    .A(A),
    .B(B),
    .MULT_END(MULT_END),
    .HI(HI),
    .LO(LO)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    A = a;
    B = b;
    MULT_START = 1'b1;
    tick(1);
    MULT_START = 1'b0;
  endtask

  // called right after the start edge: busy for 31 edges, done on the 32nd
  task automatic run_check(input string tag, input logic [31:0] hi_e, input logic [31:0] lo_e);
    for (int i = 1; i < 32; i++) begin
      tick(1);
      chk({tag, "_busy_end"}, {63'b0, MULT_END}, 64'd0);
      if (i == 16) chk({tag, "_busy_prod"}, {HI, LO}, 64'd0);
    end
    tick(1);
    chk({tag, "_end"}, {63'b0, MULT_END}, 64'd1);
    chk({tag, "_prod"}, {HI, LO}, {hi_e, lo_e});
  endtask

  initial begin
    tick(3);
    chk("reset_out", {31'b0, MULT_END, HI}, 64'd0);
    chk("reset_lo", {32'b0, LO}, 64'd0);
    reset = 1'b0;
    A = 32'h1234_5678;
    B = 32'h9abc_def0;
    tick(5);
    chk("idle_hold", {MULT_END, HI, LO[30:0]}, 64'd0);

    start(32'd3, 32'd5);
    run_check("3x5", 32'h0000_0000, 32'h0000_000F);
    start(32'hFFFF_FFFF, 32'h0000_0001);
    run_check("m1x1", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    start(32'h8000_0000, 32'h8000_0000);
    run_check("minxmin", 32'h4000_0000, 32'h0000_0000);
    start(32'hFFFF_FFFD, 32'd7);
    run_check("m3x7", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    start(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    run_check("maxxmax", 32'h3FFF_FFFF, 32'h0000_0001);
    for (int i = 0; i < 10; i++) begin
      A = 32'h1111_1111 * (i + 1);
      B = ~A;
      tick(1);
    end
    chk("done_hold_end", {63'b0, MULT_END}, 64'd1);
    chk("done_hold_prod", {HI, LO}, 64'h3FFF_FFFF_0000_0001);

    start(32'd7, 32'd9);
    tick(9);
    start(32'hFFFF_FFFE, 32'd6);
    A = 32'd100;
    B = 32'd200;
    run_check("restart", 32'hFFFF_FFFF, 32'hFFFF_FFF4);

    start(32'd4, 32'd4);
    tick(14);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("rst_abort", {31'b0, MULT_END, HI}, 64'd0);
    for (int i = 0; i < 40; i++) begin
      tick(1);
      chk("rst_quiet", {MULT_END, HI, LO[30:0]}, 64'd0);
    end

    A = 32'd2;
    B = 32'd2;
    MULT_START = 1'b1;
    reset = 1'b1;
    tick(1);
    MULT_START = 1'b0;
    reset = 1'b0;
    tick(40);
    chk("rst_prio", {31'b0, MULT_END, HI}, 64'd0);

    start(32'd2, 32'd2);
    run_check("after_rst", 32'h0, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
